// File: rtl/cam_pattern_tx_if.sv
// ----------------------------------------------------------------------------
// cam_pattern_tx_if: OV7670-style camera bus (pclk, vsync, href, byte data). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cam_pattern_tx_if;
  logic       pclk_out;
  logic       vsync;
  logic       href;
  logic [7:0] data_out;

  modport master (
    output pclk_out,
    output vsync,
    output href,
    output data_out
  );

  modport slave (
    input pclk_out,
    input vsync,
    input href,
    input data_out
  );
endinterface

`default_nettype wire

// File: rtl/cam_pattern_tx.sv
// ----------------------------------------------------------------------------
// cam_pattern_tx: YUV422 test-pattern camera source; CAM_TX_MARKER_EN adds a square marker. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cam_pattern_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        start,
  input  wire logic        continuous,
  input  wire logic [1:0]  pattern_sel,
  input  wire logic [7:0]  level,
  input  wire logic [9:0]  marker_x,
  input  wire logic [8:0]  marker_y,
  input  wire logic [5:0]  marker_r,
  cam_pattern_tx_if.master cam,
  output logic             busy,
  output logic             frame_done
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HREF_LEN = 2 * H_ACTIVE;
  localparam int CW       = $clog2(LINE_LEN + 1);
  localparam int MAX_A    = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int MAX_B    = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
  localparam int MAX_L    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LW       = $clog2(MAX_L + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBP    = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFP    = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          r_pclk;
  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;
  logic [LW-1:0] w_state_last;
  logic [9:0]    r_x;
  logic [8:0]    r_y;
  logic [1:0]    r_pat;
  logic [7:0]    r_level;
  logic          r_frame_done;
  logic          w_tick;
  logic          w_line_end;
  logic          w_state_end;
  logic          w_enter_vsync;
  logic          w_href;
  logic [7:0]    w_luma;

  // A byte period advances on the clk edge that takes pclk_out from 1 to 0.
  assign w_tick        = (r_state != S_IDLE) && r_pclk;
  assign w_line_end    = w_tick && (r_col == CW'(LINE_LEN - 1));
  assign w_state_end   = w_line_end && (r_line == w_state_last);
  assign w_enter_vsync = ((r_state == S_IDLE) && start) ||
                         ((r_state == S_VFP) && w_state_end && continuous);
  assign w_href        = (r_state == S_ACTIVE) && (r_col < CW'(HREF_LEN));

  always_comb begin
    w_state_last = '0;
    case (r_state)
      S_VSYNC:  w_state_last = LW'(VSYNC_LINES - 1);
      S_VBP:    w_state_last = LW'(VBP_LINES - 1);
      S_ACTIVE: w_state_last = LW'(V_ACTIVE - 1);
      S_VFP:    w_state_last = LW'(VFP_LINES - 1);
      default:  w_state_last = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start)       w_state_nxt = S_VSYNC;
      S_VSYNC:  if (w_state_end) w_state_nxt = S_VBP;
      S_VBP:    if (w_state_end) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_state_end) w_state_nxt = S_VFP;
      S_VFP:    if (w_state_end) w_state_nxt = continuous ? S_VSYNC : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Period/line counters and pixel clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pclk       <= 1'b0;
      r_col        <= '0;
      r_line       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pclk       <= (r_state != S_IDLE) ? ~r_pclk : 1'b0;
      r_frame_done <= (r_state == S_VFP) && w_state_end;
      if (r_state == S_IDLE) begin
        r_col  <= '0;
        r_line <= '0;
      end else if (w_tick) begin
        r_col <= w_line_end ? '0 : r_col + CW'(1);
        if (w_state_end) begin
          r_line <= '0;
        end else if (w_line_end) begin
          r_line <= r_line + LW'(1);
        end
      end
    end
  end

  // Pixel coordinates, only meaningful in ACTIVE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state != S_ACTIVE) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_tick) begin
      if (w_href && r_col[0]) begin
        r_x <= (r_x == 10'(H_ACTIVE - 1)) ? '0 : r_x + 10'd1;
      end
      if (w_line_end) begin
        r_y <= (r_y == 9'(V_ACTIVE - 1)) ? '0 : r_y + 9'd1;
      end
    end
  end

  // Frame settings are frozen for the whole frame at VSYNC entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat   <= '0;
      r_level <= '0;
    end else if (w_enter_vsync) begin
      r_pat   <= pattern_sel;
      r_level <= level;
    end
  end

`ifdef CAM_TX_MARKER_EN
  logic [9:0] r_mx;
  logic [8:0] r_my;
  logic [5:0] r_mr;
  logic [9:0] w_dx;
  logic [8:0] w_dy;
  logic       w_in_marker;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mx <= '0;
      r_my <= '0;
      r_mr <= '0;
    end else if (w_enter_vsync) begin
      r_mx <= marker_x;
      r_my <= marker_y;
      r_mr <= marker_r;
    end
  end

  assign w_dx        = (r_x >= r_mx) ? (r_x - r_mx) : (r_mx - r_x);
  assign w_dy        = (r_y >= r_my) ? (r_y - r_my) : (r_my - r_y);
  assign w_in_marker = (w_dx <= {4'b0000, r_mr}) && (w_dy <= {3'b000, r_mr});
`else
  logic w_marker_unused;
  assign w_marker_unused = ^{marker_x, marker_y, marker_r};
`endif

  always_comb begin
    w_luma = 8'h00;
    case (r_pat)
      2'd0:    w_luma = r_x[7:0];
      2'd1:    w_luma = r_y[7:0];
      2'd2:    w_luma = (r_x[3] ^ r_y[3]) ? 8'hFF : 8'h00;
      default: w_luma = r_level;
    endcase
`ifdef CAM_TX_MARKER_EN
    if (w_in_marker) begin
      w_luma = 8'hFF;
    end
`endif
  end

  // FSM outputs, decoded from registers that move only on pclk falling edges
  always_comb begin
    busy         = (r_state != S_IDLE);
    cam.vsync    = (r_state == S_VSYNC);
    cam.href     = w_href;
    cam.data_out = 8'h00;
    if (w_href) begin
      cam.data_out = r_col[0] ? 8'h80 : w_luma;
    end
  end

  assign cam.pclk_out = r_pclk;
  assign frame_done   = r_frame_done;

endmodule

`default_nettype wire

// File: doc/cam_pattern_tx.md
CAM_PATTERN_TX -- requirements
Module: cam_pattern_tx

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter H_BLANK, default 144, meaning pclk periods with href low after each line.
REQ-004 The block SHALL have parameters VSYNC_LINES, VBP_LINES and VFP_LINES, defaults 3, 17 and 10, meaning line counts for vsync, back porch and front porch.
REQ-005 The block SHALL have clock and reset ports clk (in, 1) and reset_n (in, 1); the design uses one clock, and reset is asynchronous and active-low.
REQ-006 The block SHALL have the following control inputs:
- start (in, 1): one-cycle frame request.
- continuous (in, 1): repeat frames.
- pattern_sel (in, 2): pattern select.
- level (in, 8): constant luma.
REQ-007 The block SHALL have the following marker inputs:
- marker_x (in, 10): marker centre column.
- marker_y (in, 9): marker centre row.
- marker_r (in, 6): marker half-size.
REQ-008 The block SHALL have the following camera-side outputs:
- pclk_out (out, 1): pixel clock.
- vsync (out, 1): frame sync.
- href (out, 1): line valid.
- data_out (out, 8): byte bus.
REQ-009 The block SHALL have the following status outputs:
- busy (out, 1): high outside IDLE.
- frame_done (out, 1): one-cycle pulse at end of frame.

Function
REQ-010 The block SHALL emit an OV7670-style YUV422 byte stream that the camera receiver consumes unchanged.
REQ-011 pclk_out SHALL toggle every clk cycle outside IDLE and SHALL be held at 0 in IDLE.
REQ-012 vsync, href and data_out SHALL change only on the clk edge that drives pclk_out from 1 to 0, so they are stable at every rising pclk_out.
REQ-013 LINE_LEN SHALL equal 2*H_ACTIVE+H_BLANK pclk periods, and all counters SHALL count pclk periods.
REQ-014 The FSM SHALL have the states IDLE, VSYNC, VBP, ACTIVE and VFP.
REQ-015 The FSM SHALL make the following transitions:
- IDLE to VSYNC on start.
- VSYNC to VBP after VSYNC_LINES*LINE_LEN periods.
- VBP to ACTIVE after VBP_LINES*LINE_LEN periods.
- ACTIVE to VFP after V_ACTIVE lines.
- VFP to VSYNC when continuous is 1, otherwise VFP to IDLE, after VFP_LINES*LINE_LEN periods.
REQ-016 The first vsync-high byte period SHALL begin on the first pclk_out falling edge after start.
REQ-017 vsync SHALL be 1 only in VSYNC.
REQ-018 In ACTIVE, href SHALL be 1 for the first 2*H_ACTIVE periods of each line and 0 for the remaining H_BLANK periods.
REQ-019 href SHALL be 0 in every state other than ACTIVE.
REQ-020 While href is 1, bytes SHALL alternate Y, chroma per pixel, starting with Y at x=0; chroma SHALL be 0x80.
REQ-021 While href is 0, data_out SHALL be 0x00.
REQ-022 Luma at pixel (x,y) SHALL be selected by pattern_sel as follows:
- 0: x[7:0].
- 1: y[7:0].
- 2: 0xFF when x[3]^y[3] is 1, else 0x00.
- 3: level.
REQ-023 pattern_sel, level and the marker inputs SHALL be latched on entry to VSYNC, and changes mid-frame SHALL NOT affect the current frame.
REQ-024 frame_done SHALL pulse for exactly one clk cycle on the cycle that VFP ends.
REQ-025 start SHALL be ignored while busy is 1.
REQ-026 Deasserting continuous mid-frame SHALL let the current frame complete, after which the FSM goes to IDLE.
REQ-027 Assertion of start and the end of VFP in the same cycle with continuous=0 SHALL go to IDLE, and start SHALL be dropped.
REQ-028 The x and y counters SHALL wrap to 0 at H_ACTIVE and V_ACTIVE respectively, without overflow into other fields.

Reset
REQ-029 While reset_n is 0, all outputs SHALL be 0 immediately, the FSM SHALL be in IDLE, and all counters and latched inputs SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame, frame_done SHALL NOT pulse, and after release the block SHALL wait for start.

Configuration
REQ-031 With macro CAM_TX_MARKER_EN defined, luma SHALL be 0xFF for every pixel with |x-marker_x|<=marker_r and |y-marker_y|<=marker_r, overriding the pattern.
REQ-032 Without CAM_TX_MARKER_EN, the marker inputs SHALL be unused and no marker logic SHALL be synthesized.

Verification
Bench parameters for REQ-033 to REQ-037 are H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2 and VSYNC/VBP/VFP=1, giving LINE_LEN=10 and a frame of 50 pclk periods.
REQ-033 Reset release followed by a start pulse with pattern_sel=0 SHALL produce:
- 10 periods with vsync high.
- 10 periods with href low.
- 2 lines of bytes 00,80,01,80,02,80,03,80 each.
- frame_done 100 clk cycles after start.
REQ-034 With continuous=1, the second frame's vsync SHALL start on the period immediately after VFP; deasserting continuous in the second frame SHALL end at IDLE with busy=0.
REQ-035 With pattern_sel=3 and level=0x5A, changing level to 0x11 mid-ACTIVE SHALL keep the current frame at 0x5A and give 0x11 in the next frame.
REQ-036 With CAM_TX_MARKER_EN defined, marker_x=1, marker_y=0 and marker_r=0, only pixel (1,0) SHALL have Y=0xFF.
REQ-037 Asserting reset_n=0 during ACTIVE SHALL force all outputs to 0 in the same cycle with no frame_done, and start pulses during busy SHALL have no effect.
